// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared Simon Says types, colour codes and sequence geometry
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] C_GREEN  = 2'b00;
    localparam logic [1:0] C_RED    = 2'b01;
    localparam logic [1:0] C_YELLOW = 2'b10;
    localparam logic [1:0] C_BLUE   = 2'b11;

    localparam int MAX_ROUND = 14;
    localparam int SEQ_W     = 32;
    localparam int STEP_W    = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - release debounce: pulses once btn has stayed all-zero long enough
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] btn,
    output logic       released_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          released_q, released_d;

    always_comb begin
        cnt_d      = cnt_q;
        released_d = 1'b0;
        // Any bounce back to a nonzero level restarts the quiet window.
        if (!en || btn != 4'd0) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            released_d = 1'b1;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            released_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            released_q <= released_d;
        end
    end

    assign released_pulse = released_q;

endmodule

// File: rtl/play_state.sv
// rtl/play_state.sv - player input capture: debounce, encode and pack button presses
module play_state
    import simon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_play,
    input  logic [3:0]       round_ctr_in,
    input  logic [3:0]       btn,
    output logic [SEQ_W-1:0] seq_out_play,
    output logic [3:0]       press_count,
    output logic [3:0]       led_echo,
    output logic             busy,
    output logic             complete_play,
    output logic             timeout_play
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [3:0]       pcnt_q, pcnt_d;
    logic [3:0]       target_q, target_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [3:0]       held_q, held_d;
    logic             busy_q, busy_d;
    logic             complete_q, complete_d;
    logic             timeout_q, timeout_d;

    logic             released;
    logic             one_hot;
    logic [1:0]       code;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (state_q == WAIT_RELEASE),
        .btn            (btn),
        .released_pulse (released)
    );

    assign one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);

    always_comb begin
        case (btn)
            4'b0001: code = C_GREEN;
            4'b0010: code = C_RED;
            4'b0100: code = C_YELLOW;
            4'b1000: code = C_BLUE;
            default: code = C_GREEN;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        pcnt_d     = pcnt_q;
        target_d   = target_q;
        tcnt_d     = tcnt_q;
        held_d     = held_q;
        complete_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_play) begin
                    seq_d    = '0;
                    pcnt_d   = 4'd0;
                    tcnt_d   = '0;
                    target_d = (round_ctr_in > 4'(MAX_ROUND)) ? 4'(MAX_ROUND) + 4'd1
                                                              : round_ctr_in + 4'd1;
                    state_d  = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // A valid press on the expiry cycle takes priority over the timeout.
                if (one_hot) begin
                    seq_d   = seq_q | (SEQ_W'(code) << {pcnt_q, 1'b0});
                    pcnt_d  = pcnt_q + 4'd1;
                    tcnt_d  = '0;
                    held_d  = btn;
                    state_d = WAIT_RELEASE;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    tcnt_d    = '0;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (released) begin
                    held_d = 4'd0;
                    if (pcnt_q == target_q) begin
                        complete_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tcnt_d  = '0;
                        state_d = WAIT_PRESS;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                held_d  = 4'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            pcnt_q     <= 4'd0;
            target_q   <= 4'd0;
            tcnt_q     <= '0;
            held_q     <= 4'd0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            pcnt_q     <= pcnt_d;
            target_q   <= target_d;
            tcnt_q     <= tcnt_d;
            held_q     <= held_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            timeout_q  <= timeout_d;
        end
    end

    assign seq_out_play  = seq_q;
    assign press_count   = pcnt_q;
    assign led_echo      = held_q;
    assign busy          = busy_q;
    assign complete_play = complete_q;
    assign timeout_play  = timeout_q;

endmodule

// File: tb/tb_play_state.sv
// tb/tb_play_state.sv - self-checking bench for play_state against a press-level model
module tb_play_state;

    localparam int TO  = 50;
    localparam int DEB = 4;

    logic        clk;
    logic        rst_n;
    logic        en_play;
    logic [3:0]  round_ctr_in;
    logic [3:0]  btn;
    logic [31:0] seq_out_play;
    logic [3:0]  press_count;
    logic [3:0]  led_echo;
    logic        busy;
    logic        complete_play;
    logic        timeout_play;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] exp_seq;
    int          exp_cnt;
    int          exp_target;

    play_state #(
        .TIMEOUT_CYCLES  (TO),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_play       (en_play),
        .round_ctr_in  (round_ctr_in),
        .btn           (btn),
        .seq_out_play  (seq_out_play),
        .press_count   (press_count),
        .led_echo      (led_echo),
        .busy          (busy),
        .complete_play (complete_play),
        .timeout_play  (timeout_play)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (seq_out_play !== 32'd0) begin n_fail++; $display("FAIL %s seq: got %h expected 0", tag, seq_out_play); end
        n_checks++;
        if (press_count !== 4'd0) begin n_fail++; $display("FAIL %s press_count: got %0d expected 0", tag, press_count); end
        n_checks++;
        if (led_echo !== 4'd0) begin n_fail++; $display("FAIL %s led_echo: got %b expected 0", tag, led_echo); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
        n_checks++;
        if (complete_play !== 1'b0) begin n_fail++; $display("FAIL %s complete: got %b expected 0", tag, complete_play); end
        n_checks++;
        if (timeout_play !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got %b expected 0", tag, timeout_play); end
    endtask

    task automatic start_round(input int r);
        round_ctr_in = 4'(r);
        en_play      = 1'b1;
        tick();
        en_play      = 1'b0;
        exp_seq      = 32'd0;
        exp_cnt      = 0;
        exp_target   = ((r > 14) ? 14 : r) + 1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL start busy: got %b expected 1", busy); end
    endtask

    // One full press: optional multi-hot noise, a held button, then release and debounce.
    task automatic press(input logic [3:0] b, input int hold, input int noise, input int gap);
        int idx;
        bit fin;
        for (int i = 0; i < noise; i++) begin
            btn = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
            tick();
        end
        if (noise > 0) begin
            n_checks++;
            if (press_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL noise press_count: got %0d expected %0d", press_count, exp_cnt); end
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (b[i]) idx = i;
        exp_seq = exp_seq | (32'(idx) << (2 * exp_cnt));
        exp_cnt++;
        fin = (exp_cnt == exp_target);
        btn = b;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == 0) begin
                n_checks++;
                if (led_echo !== b) begin n_fail++; $display("FAIL led_echo: got %b expected %b", led_echo, b); end
                n_checks++;
                if (press_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL press_count after press: got %0d expected %0d", press_count, exp_cnt); end
            end
        end
        btn = 4'd0;
        for (int k = 1; k <= DEB + 1; k++) begin
            tick();
            n_checks++;
            if (complete_play !== (fin && k == DEB + 1)) begin
                n_fail++; $display("FAIL complete timing k=%0d: got %b expected %b", k, complete_play, fin && k == DEB + 1);
            end
            n_checks++;
            if (timeout_play !== 1'b0) begin n_fail++; $display("FAIL stray timeout: got %b expected 0", timeout_play); end
        end
        n_checks++;
        if (seq_out_play !== exp_seq) begin n_fail++; $display("FAIL seq: got %h expected %h", seq_out_play, exp_seq); end
        n_checks++;
        if (busy !== !fin) begin n_fail++; $display("FAIL busy after release: got %b expected %b", busy, !fin); end
        if (fin) begin
            n_checks++;
            if (press_count !== 4'(exp_target)) begin n_fail++; $display("FAIL final press_count: got %0d expected %0d", press_count, exp_target); end
            tick();
            n_checks++;
            if (complete_play !== 1'b0) begin n_fail++; $display("FAIL complete width: got %b expected 0", complete_play); end
        end
        for (int i = 0; i < gap; i++) begin
            tick();
            n_checks++;
            if (complete_play !== 1'b0) begin n_fail++; $display("FAIL gap complete: got %b expected 0", complete_play); end
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset");
    endtask

    task automatic test_round0();
        start_round(0);
        press(4'b0100, 3, 0, 0);
        n_checks++;
        if (seq_out_play !== 32'h0000_0002) begin n_fail++; $display("FAIL round0 seq: got %h expected 00000002", seq_out_play); end
    endtask

    task automatic test_round2();
        start_round(2);
        press(4'b0001, $urandom_range(1, 4), 0, $urandom_range(0, 3));
        press(4'b1000, $urandom_range(1, 4), 0, $urandom_range(0, 3));
        press(4'b0010, $urandom_range(1, 4), 0, 0);
        n_checks++;
        if (seq_out_play !== 32'h0000_001C) begin n_fail++; $display("FAIL round2 seq: got %h expected 0000001c", seq_out_play); end
    endtask

    task automatic test_round14_clamp();
        for (int r = 14; r <= 15; r++) begin
            start_round(r);
            for (int p = 0; p < 15; p++) press(4'b1000, 1, 0, 0);
            n_checks++;
            if (seq_out_play !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL round%0d seq: got %h expected 3fffffff", r, seq_out_play); end
            n_checks++;
            if (press_count !== 4'd15) begin n_fail++; $display("FAIL round%0d press_count: got %0d expected 15", r, press_count); end
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        for (int it = 0; it < 6; it++) begin
            start_round($urandom_range(0, 6));
            while (exp_cnt < exp_target) begin
                b = 4'b0001 << $urandom_range(0, 3);
                press(b, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
    endtask

    task automatic test_invalid_bounce();
        start_round(0);
        btn = 4'b0011;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (press_count !== 4'd0) begin n_fail++; $display("FAIL multi-hot press_count: got %0d expected 0", press_count); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL multi-hot busy: got %b expected 1", busy); end
        btn = 4'b0100;
        tick();
        btn = 4'd0;
        tick();
        tick();
        btn = 4'b0100;
        tick();
        tick();
        n_checks++;
        if (press_count !== 4'd1) begin n_fail++; $display("FAIL bounce press_count: got %0d expected 1", press_count); end
        n_checks++;
        if (complete_play !== 1'b0) begin n_fail++; $display("FAIL bounce early complete: got %b expected 0", complete_play); end
        btn = 4'd0;
        for (int k = 1; k <= DEB + 1; k++) begin
            tick();
            n_checks++;
            if (complete_play !== (k == DEB + 1)) begin n_fail++; $display("FAIL bounce complete k=%0d: got %b expected %b", k, complete_play, k == DEB + 1); end
        end
        n_checks++;
        if (seq_out_play !== 32'h0000_0002) begin n_fail++; $display("FAIL bounce seq: got %h expected 00000002", seq_out_play); end
        tick();
    endtask

    task automatic test_timeout();
        start_round(1);
        press(4'b0001, 2, 0, 0);
        for (int j = 1; j <= TO; j++) begin
            tick();
            n_checks++;
            if (timeout_play !== (j == TO)) begin n_fail++; $display("FAIL timeout j=%0d: got %b expected %b", j, timeout_play, j == TO); end
            n_checks++;
            if (complete_play !== 1'b0) begin n_fail++; $display("FAIL complete during stall: got %b expected 0", complete_play); end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout busy: got %b expected 0", busy); end
        n_checks++;
        if (press_count !== 4'd1) begin n_fail++; $display("FAIL timeout press_count: got %0d expected 1", press_count); end
        n_checks++;
        if (seq_out_play !== 32'd0) begin n_fail++; $display("FAIL timeout seq: got %h expected 0", seq_out_play); end
        tick();
        n_checks++;
        if (timeout_play !== 1'b0) begin n_fail++; $display("FAIL timeout width: got %b expected 0", timeout_play); end
    endtask

    task automatic test_reset_mid();
        start_round(3);
        press(4'b1000, 1, 0, 0);
        btn = 4'b0100;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        btn = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (complete_play !== 1'b0 || timeout_play !== 1'b0) begin
                n_fail++; $display("FAIL pulse in reset: got %b%b expected 00", complete_play, timeout_play);
            end
        end
        rst_n = 1'b1;
        tick();
        start_round(0);
        press(4'b0010, 2, 0, 0);
        n_checks++;
        if (seq_out_play !== 32'h0000_0001) begin n_fail++; $display("FAIL post-reset seq: got %h expected 00000001", seq_out_play); end
    endtask

    task automatic test_busy_en();
        start_round(2);
        press(4'b1000, 2, 0, 0);
        round_ctr_in = 4'd0;
        en_play      = 1'b1;
        tick();
        en_play      = 1'b0;
        n_checks++;
        if (press_count !== 4'd1) begin n_fail++; $display("FAIL busy en press_count: got %0d expected 1", press_count); end
        n_checks++;
        if (seq_out_play !== 32'h0000_0003) begin n_fail++; $display("FAIL busy en seq: got %h expected 00000003", seq_out_play); end
        btn = 4'b0001;
        en_play = 1'b1;
        tick();
        en_play = 1'b0;
        btn = 4'd0;
        exp_cnt++;
        for (int k = 1; k <= DEB + 1; k++) tick();
        n_checks++;
        if (press_count !== 4'd2) begin n_fail++; $display("FAIL busy en release press_count: got %0d expected 2", press_count); end
        press(4'b0010, 2, 0, 0);
        n_checks++;
        if (seq_out_play !== 32'h0000_0013) begin n_fail++; $display("FAIL busy en final seq: got %h expected 00000013", seq_out_play); end
    endtask

    initial begin
        rst_n        = 1'b0;
        en_play      = 1'b0;
        round_ctr_in = 4'd0;
        btn          = 4'd0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_round0();
        test_round2();
        test_round14_clamp();
        test_random();
        test_invalid_bounce();
        test_timeout();
        test_reset_mid();
        test_busy_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/play_state.md
Name: play_state

Overview:
- Player-input capture state of the Simon Says game.
- After the display state has shown the pattern, this block debounces button presses, encodes each one to a 2-bit code and packs them into a 32-bit sequence.
- It hands the sequence to check_state on seq_in_check, with a one-cycle complete pulse.
- It produces the player sequence that check_state compares against seq_mem, and flags a timeout if the player stalls.

Parameters:
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted presses before timeout (≥2).
- DEBOUNCE_CYCLES, 4, consecutive all-released cycles required before a press counts as finished (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_play  in  1  one-cycle start pulse from the controller.
- round_ctr_in  in  4  current round, 0..14; round r needs r+1 presses.
- btn  in  4  synchronized button levels, bit i = colour i.
- seq_out_play  out  32  packed player sequence, goes to check_state seq_in_check.
- press_count  out  4  presses accepted so far this round.
- led_echo  out  4  mirrors the held valid button while in WAIT_RELEASE, else 0.
- busy  out  1  high in any state other than IDLE.
- complete_play  out  1  one-cycle pulse: all presses captured, goes to check_state en_check.
- timeout_play  out  1  one-cycle pulse: player stalled.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all outputs 0; seq_out_play=0; internal counters 0. Takes effect mid-operation with no completion or timeout pulse.
- Encoding: btn 0001→2'b00, 0010→01, 0100→10, 1000→11. Step k occupies seq_out_play[2k+1:2k] (LSB-first, same packing as seq_mem). Unused upper bits stay 0.
- Target: on accepted en_play, latch target = min(round_ctr_in,14)+1. Values 15 clamp to 14.
- IDLE:
  - On en_play: clear seq_out_play, press_count, timeout counter and debounce counter; go to WAIT_PRESS.
  - Otherwise hold seq_out_play (check_state samples it after complete_play).
- WAIT_PRESS:
  - Timeout counter increments every cycle.
  - btn exactly one-hot: write code into slot press_count, press_count+1, reset timeout counter, go to WAIT_RELEASE. The register update is visible the next cycle.
  - btn zero or multi-hot: no effect; the timeout counter still runs.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no valid press: timeout_play=1 for one cycle, go to IDLE. press_count and seq keep their partial values.
  - A valid press on the expiry cycle wins over the timeout.
- WAIT_RELEASE:
  - led_echo = latched button.
  - Debounce counter increments while btn==0 and clears to 0 on any nonzero btn (bounce). No new press is accepted here.
  - Counter reaching DEBOUNCE_CYCLES-1 with btn==0 on that cycle:
    - if press_count==target: complete_play=1 next cycle, go to IDLE;
    - else clear debounce and timeout counters, go to WAIT_PRESS.
- en_play while busy: ignored.
- Latency from the final release edge to complete_play: DEBOUNCE_CYCLES+1 cycles.
- complete_play and timeout_play are mutually exclusive and never both high.

Decomposition:
- Shared package simon_pkg holds:
  - state enum {IDLE, WAIT_PRESS, WAIT_RELEASE};
  - colour codes C_GREEN=2'b00 … C_BLUE=2'b11;
  - MAX_ROUND=14, SEQ_W=32, STEP_W=2.
- check_state and the display state import the same package.
- Sub-module btn_debounce: release-debounce counter with a DEBOUNCE_CYCLES parameter. Outputs released_pulse, restarts on any nonzero input.
- The one-hot encoder stays inline.

Test Plan (TIMEOUT_CYCLES=50, DEBOUNCE_CYCLES=4):
- Round 0: en_play, btn=0100 for 3 cycles, then 0 → complete_play pulse exactly 5 cycles after release; seq_out_play=32'h0000_0002; press_count=1; timeout_play stays 0.
- Round 2: presses 0001, 1000, 0010, each released ≥4 cycles → seq_out_play=32'h0000_001C; one complete_play after the third release only.
- Round 14: 15 presses of 1000 → seq_out_play=32'h3FFF_FFFF, press_count=15, complete_play=1. Round_ctr_in=15 gives the same result (clamp).
- Invalid and bounce:
  - btn=0011 for 10 cycles → press_count stays 0.
  - Release 2 cycles, then btn=0100 again, then release 4 cycles → counted as a single press with code 10.
- Timeout: round 1, one press released, then idle 50 cycles → timeout_play pulse; complete_play never asserts; busy=0; press_count=1.
- Reset and busy:
  - rst_n low mid-WAIT_RELEASE → all outputs 0 immediately and no pulse; next en_play starts clean.
  - en_play while busy → no clear, no effect.
